rv32_wb_arbiter: RTL and testbench
==================================

# rv32_wb_arbiter

Writeback arbiter for the RV32 core. It merges result streams from three producers onto the single general-register-file write port:

- the ALU, which has no backpressure;
- the load/store unit (LSU);
- the multiply/divide unit (MDU).

It drives the write port's active-low enable, ID and data from a registered output stage, and exports the same registered stage as a forwarding source for decode. Fixed priority plus a starvation counter guarantees MDU forward progress.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive cycles the MDU may be refused before it is promoted above the LSU (legal range 1..15).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU result present this cycle (must be accepted)
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- lsu_valid  in  1  load result offered
- lsu_ready  out  1  load result accepted this cycle (combinational)
- lsu_rd  in  5  load destination register
- lsu_data  in  32  load data
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  MDU result accepted this cycle (combinational)
- mdu_rd  in  5  MDU destination register
- mdu_data  in  32  MDU result
- wb_we_n  out  1  register-file write enable, active-low
- wb_id  out  5  register-file write ID
- wb_data  out  32  register-file write data
- fwd_valid  out  1  forwarding entry valid (equals !wb_we_n)
- fwd_rd  out  5  forwarding register ID (equals wb_id)
- fwd_data  out  32  forwarding data (equals wb_data)
- mdu_starved  out  1  MDU currently promoted (debug/perf)

## Operation
- Handshake rules:
  - LSU and MDU use valid/ready; a transfer occurs on a clock edge where valid && ready.
  - A producer holds rd and data stable while valid && !ready.
- Grant per cycle, exactly one winner at most:
  1. ALU if alu_valid.
  2. Otherwise, the MDU if mdu_valid && promoted.
  3. Otherwise, the LSU if lsu_valid.
  4. Otherwise, the MDU if mdu_valid.
- Ready equations:
  - lsu_ready = !alu_valid && !(mdu_valid && promoted).
  - mdu_ready = !alu_valid && (promoted || !lsu_valid).
- Starvation counter (4 bits):
  - Increments, saturating at STARVE_MAX, each cycle mdu_valid && !mdu_ready.
  - Clears on an MDU transfer or when mdu_valid=0.
  - promoted = (counter == STARVE_MAX).
  - mdu_starved = promoted.
- Output register, loaded every edge:
  - If a winner exists: wb_id <= winner rd and wb_data <= winner data.
  - wb_we_n <= 0 if winner rd != 0; wb_we_n <= 1 if winner rd == 0. A write to x0 is consumed with enable deasserted.
  - If no winner: wb_we_n <= 1, and wb_id/wb_data hold their previous values.
- fwd_* are wired copies of the wb_* stage, so decode can bypass a value not yet in the register file.
- Reset values (asynchronous, while rst=0):
  - wb_we_n=1, wb_id=0, wb_data=0.
  - fwd_valid=0, starvation counter=0, mdu_starved=0.
  - lsu_ready and mdu_ready follow their equations. With counter=0: mdu_ready=!alu_valid&&!lsu_valid, and lsu_ready=!alu_valid.
- Reset mid-operation: the output stage is cleared and any pending write is lost. Producers are reset in the same domain, so no replay is needed.

## Timing
- Latency: a result granted at edge N appears on wb_*/fwd_* in cycle N..N+1 and is written to the register file at edge N+1.
- Throughput: one write per cycle; no bubbles when there are back-to-back grants.
- All three valid in the same cycle: the ALU is taken, and both ready outputs are 0.
- Worst-case MDU wait under continuous LSU traffic with no ALU traffic: STARVE_MAX refused cycles, then a grant on the next cycle.
- ALU traffic can block the MDU indefinitely by design; the counter saturates and does not wrap.

## Test plan
- Reset: hold rst=0 with all producers valid -> wb_we_n=1, wb_id=0, wb_data=0, fwd_valid=0; after rst=1, the first edge writes the ALU result.
- Single ALU write: alu_valid=1, rd=5, data=0x12345678 for one cycle -> next cycle wb_we_n=0, wb_id=5, wb_data=0x12345678; following cycle wb_we_n=1.
- Collision: ALU (rd=1, 0xA), LSU (rd=2, 0xB) and MDU (rd=3, 0xC) all valid at once -> outputs in order rd1/0xA, rd2/0xB, rd3/0xC on three consecutive cycles; lsu_ready=0 in cycle 0 and mdu_ready=0 in cycles 0-1.
- Starvation with STARVE_MAX=4: LSU valid continuously and MDU valid (rd=7, 0xDEAD) from cycle 0 -> mdu_ready=0 in cycles 0-3, mdu_starved=1 and mdu_ready=1 in cycle 4, and wb_id=7 in cycle 5; the counter then returns to 0.
- x0 write: LSU rd=0, data=0xFFFFFFFF -> lsu_ready=1, next cycle wb_we_n=1, wb_id=0.
- Asynchronous reset mid-burst: assert rst=0 between clock edges while wb_we_n=0 -> wb_we_n=1 and mdu_starved=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv32_wb_arbiter.sv
// rv32_wb_arbiter: fixed-priority writeback arbiter (ALU > promoted MDU > LSU > MDU) with MDU starvation promotion
module rv32_wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        wb_we_n,
  output logic [4:0]  wb_id,
  output logic [31:0] wb_data,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic        mdu_starved
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [3:0]  cnt;
  logic        promoted, win, pick_mdu;
  logic [4:0]  win_rd;
  logic [31:0] win_data;
  assign promoted    = cnt == SMAX;
  assign mdu_starved = promoted;
  assign lsu_ready   = !alu_valid && !(mdu_valid && promoted);
  assign mdu_ready   = !alu_valid && (promoted || !lsu_valid);
  assign fwd_valid   = !wb_we_n;
  assign fwd_rd      = wb_id;
  assign fwd_data    = wb_data;
  always_comb begin
    pick_mdu = mdu_valid && mdu_ready;
    win      = alu_valid || lsu_valid || mdu_valid;
    win_rd   = alu_valid ? alu_rd : pick_mdu ? mdu_rd : lsu_rd;
    win_data = alu_valid ? alu_data : pick_mdu ? mdu_data : lsu_data;
  end
  // x0 writes are consumed but leave the enable deasserted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= 4'd0;
      wb_we_n <= 1'b1;
      wb_id   <= 5'd0;
      wb_data <= 32'd0;
    end else begin
      wb_we_n <= !(win && win_rd != 5'd0);
      if (win) begin
        wb_id   <= win_rd;
        wb_data <= win_data;
      end
      cnt <= (!mdu_valid || mdu_ready) ? 4'd0 : promoted ? cnt : cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// tb_rv32_wb_arbiter: directed stimulus with a write scoreboard checked by an independent monitor
module tb_rv32_wb_arbiter;
  logic        clk, rst;
  logic        alu_valid, lsu_valid, mdu_valid;
  logic [4:0]  alu_rd, lsu_rd, mdu_rd;
  logic [31:0] alu_data, lsu_data, mdu_data;
  logic        lsu_ready, mdu_ready, wb_we_n, fwd_valid, mdu_starved;
  logic [4:0]  wb_id, fwd_rd;
  logic [31:0] wb_data, fwd_data;
  int total = 0;
  int bad = 0;
  typedef struct { logic [4:0] id; logic [31:0] d; } wr_t;
  wr_t q[$];

  rv32_wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .wb_we_n(wb_we_n), .wb_id(wb_id), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .mdu_starved(mdu_starved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] id, input logic [31:0] d);
    wr_t w;
    w.id = id;
    w.d  = d;
    q.push_back(w);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0;
    lsu_valid = 0;
    mdu_valid = 0;
  endtask

  always @(negedge clk) begin
    if (!wb_we_n) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got id=%0d data=0x%0h expected none", wb_id, wb_data);
      end else begin
        wr_t w;
        w = q.pop_front();
        chk("wb_id", 32'(wb_id), 32'(w.id));
        chk("wb_data", wb_data, w.d);
        chk("fwd_valid", 32'(fwd_valid), 32'd1);
        chk("fwd_rd", 32'(fwd_rd), 32'(w.id));
        chk("fwd_data", fwd_data, w.d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0;
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
    lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'h22;
    mdu_valid = 1; mdu_rd = 5'd3; mdu_data = 32'h33;
    @(negedge clk);
    chk("rst_we_n", 32'(wb_we_n), 32'd1);
    chk("rst_id", 32'(wb_id), 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_starved", 32'(mdu_starved), 32'd0);
    chk("rst_lsu_ready", 32'(lsu_ready), 32'd0);
    chk("rst_mdu_ready", 32'(mdu_ready), 32'd0);
    rst = 1;
    push(5'd9, 32'h99);
    cyc();
    idle();
    cyc();
    cyc();

    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h12345678;
    push(5'd5, 32'h12345678);
    cyc();
    idle();
    @(negedge clk);
    chk("single_we_n", 32'(wb_we_n), 32'd0);
    cyc();
    @(negedge clk);
    chk("single_after_we_n", 32'(wb_we_n), 32'd1);
    cyc();

    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hA;
    lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'hB;
    mdu_valid = 1; mdu_rd = 5'd3; mdu_data = 32'hC;
    push(5'd1, 32'hA); push(5'd2, 32'hB); push(5'd3, 32'hC);
    @(negedge clk);
    chk("col0_lsu_ready", 32'(lsu_ready), 32'd0);
    chk("col0_mdu_ready", 32'(mdu_ready), 32'd0);
    cyc();
    alu_valid = 0;
    @(negedge clk);
    chk("col1_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("col1_mdu_ready", 32'(mdu_ready), 32'd0);
    cyc();
    lsu_valid = 0;
    @(negedge clk);
    chk("col2_mdu_ready", 32'(mdu_ready), 32'd1);
    cyc();
    idle();
    cyc();
    cyc();

    lsu_valid = 1; lsu_rd = 5'd10;
    mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'hDEAD;
    for (int k = 0; k < 4; k++) begin
      lsu_data = 32'(k);
      push(5'd10, 32'(k));
      @(negedge clk);
      chk("starve_mdu_ready", 32'(mdu_ready), 32'd0);
      chk("starve_flag_low", 32'(mdu_starved), 32'd0);
      chk("starve_lsu_ready", 32'(lsu_ready), 32'd1);
      cyc();
    end
    lsu_data = 32'd4;
    push(5'd7, 32'hDEAD);
    @(negedge clk);
    chk("promo_starved", 32'(mdu_starved), 32'd1);
    chk("promo_mdu_ready", 32'(mdu_ready), 32'd1);
    chk("promo_lsu_ready", 32'(lsu_ready), 32'd0);
    cyc();
    mdu_valid = 0;
    push(5'd10, 32'd4);
    @(negedge clk);
    chk("starve_cleared", 32'(mdu_starved), 32'd0);
    chk("post_lsu_ready", 32'(lsu_ready), 32'd1);
    cyc();
    idle();
    cyc();
    cyc();

    lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'hFFFFFFFF;
    @(negedge clk);
    chk("x0_lsu_ready", 32'(lsu_ready), 32'd1);
    cyc();
    idle();
    @(negedge clk);
    chk("x0_we_n", 32'(wb_we_n), 32'd1);
    chk("x0_id", 32'(wb_id), 32'd0);
    chk("x0_data", wb_data, 32'hFFFFFFFF);
    cyc();

    mdu_valid = 1; mdu_rd = 5'd3; mdu_data = 32'h77;
    for (int k = 0; k < 5; k++) begin
      alu_valid = 1; alu_rd = 5'(12 + k); alu_data = 32'(k + 100);
      if (k < 4) push(5'(12 + k), 32'(k + 100));
      cyc();
    end
    chk("pre_arst_we_n", 32'(wb_we_n), 32'd0);
    chk("pre_arst_starved", 32'(mdu_starved), 32'd1);
    #2;
    rst = 0;
    #1;
    chk("arst_we_n", 32'(wb_we_n), 32'd1);
    chk("arst_starved", 32'(mdu_starved), 32'd0);
    chk("arst_id", 32'(wb_id), 32'd0);
    chk("arst_data", wb_data, 32'd0);
    idle();
    @(negedge clk);
    rst = 1;
    cyc();
    cyc();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
